mc_control_fsm: RTL

Parametrised multi-cycle RV32I control unit: next generation of the core's state-machine controller. It sequences fetch, decode, execute, memory and writeback. It adds memory ready/wait-state handshakes with a timeout, sub-word byte-enable generation with misalignment trapping, LUI/AUIPC support, a sticky error state, and parametrised instruction/cycle counters. It sits between the instruction register and the datapath muxes, ALU, register file, PC and the instruction/data memory ports.

---
 rtl/mc_control_fsm.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory wait-state handshakes with timeout, byte-enable generation and a sticky error state.
module mc_control_fsm #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       OPCODE,
  input  logic [2:0]       FUNCT3,
  input  logic [1:0]       ADDR_LSB,
  input  logic             I_MEM_RDY,
  input  logic             D_MEM_RDY,
  output logic             IR_WR,
  output logic             PC_WR,
  output logic             PC_WRITE_COND,
  output logic             RF_WE,
  output logic             ALU_WR,
  output logic             MUX1,
  output logic             MUX4,
  output logic             REWR_MUX,
  output logic [1:0]       MUX2,
  output logic [10:0]      ALU_CONTROL,
  output logic             I_MEM_CSN,
  output logic             D_MEM_CSN,
  output logic             D_MEM_WEN,
  output logic [3:0]       D_MEM_BE,
  output logic [3:0]       STATE,
  output logic             ERR,
  output logic [CNT_W-1:0] NUM_INST,
  output logic [CNT_W-1:0] NUM_CYCLE
);

  typedef enum logic [3:0] {
    S_U_EX    = 4'd0,
    S_IF      = 4'd1,
    S_ID      = 4'd2,
    S_JAL_EX  = 4'd3,
    S_BR_ID   = 4'd4,
    S_LI_EX   = 4'd5,
    S_SW_EX   = 4'd6,
    S_R_EX    = 4'd7,
    S_JALR_EX = 4'd8,
    S_BR_EX   = 4'd9,
    S_WB      = 4'd11,
    S_LW_MEM  = 4'd12,
    S_LW_WB   = 4'd13,
    S_SW_MEM  = 4'd14,
    S_ERR     = 4'd15
  } state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  state_t            state, state_nxt, dec_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              in_wait, rdy, timeout, misaligned;
  logic [3:0]        be_calc;
  logic              unused_funct3;

  // Sign/zero-extension bit does not affect byte enables.
  assign unused_funct3 = FUNCT3[2];

  assign in_wait = (state == S_IF) || (state == S_LW_MEM) || (state == S_SW_MEM);
  assign rdy     = (state == S_IF) ? I_MEM_RDY : D_MEM_RDY;
  assign timeout = (WAIT_MAX != 0) && in_wait && !rdy && (wait_cnt == WAIT_W'(WAIT_MAX));

  always_comb begin
    be_calc    = '0;
    misaligned = 1'b0;
    case (FUNCT3[1:0])
      2'b00: be_calc = 4'b0001 << ADDR_LSB;
      2'b01: begin
        if (ADDR_LSB[0]) misaligned = 1'b1;
        else             be_calc    = 4'b0011 << ADDR_LSB;
      end
      2'b10: begin
        if (ADDR_LSB != 2'b00) misaligned = 1'b1;
        else                   be_calc    = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IF;
      wait_cnt  <= '0;
      NUM_INST  <= '0;
      NUM_CYCLE <= '0;
    end else begin
      state <= state_nxt;
      if (!in_wait || rdy || (state_nxt != state)) wait_cnt <= '0;
      else                                          wait_cnt <= wait_cnt + WAIT_W'(1);
      if ((state == S_IF) && I_MEM_RDY) NUM_INST  <= NUM_INST + CNT_W'(1);
      if (state != S_ERR)               NUM_CYCLE <= NUM_CYCLE + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IF: begin
        if (I_MEM_RDY) begin
          case (OPCODE)
            OP_JAL:                                    state_nxt = S_JAL_EX;
            OP_BRANCH:                                 state_nxt = S_BR_ID;
            OP_LUI, OP_AUIPC:                          state_nxt = S_U_EX;
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_JALR:    state_nxt = S_ID;
            default:                                   state_nxt = S_ERR;
          endcase
        end
      end
      S_ID: begin
        case (OPCODE)
          OP_R:           state_nxt = S_R_EX;
          OP_I, OP_LOAD:  state_nxt = S_LI_EX;
          OP_STORE:       state_nxt = S_SW_EX;
          OP_JALR:        state_nxt = S_JALR_EX;
          default:        state_nxt = S_ERR;
        endcase
      end
      S_U_EX, S_JAL_EX, S_R_EX, S_JALR_EX: state_nxt = S_WB;
      S_BR_ID:   state_nxt = S_BR_EX;
      S_LI_EX: begin
        case (OPCODE)
          OP_I:    state_nxt = S_WB;
          OP_LOAD: state_nxt = S_LW_MEM;
          default: state_nxt = S_ERR;
        endcase
      end
      S_SW_EX:   state_nxt = S_SW_MEM;
      S_BR_EX:   state_nxt = S_IF;
      S_WB:      state_nxt = S_IF;
      S_LW_MEM: begin
        if (misaligned)     state_nxt = S_ERR;
        else if (D_MEM_RDY) state_nxt = S_LW_WB;
      end
      S_LW_WB:   state_nxt = S_IF;
      S_SW_MEM: begin
        if (misaligned)     state_nxt = S_ERR;
        else if (D_MEM_RDY) state_nxt = S_IF;
      end
      default:   state_nxt = S_ERR;
    endcase
    if (timeout) state_nxt = S_ERR;
  end

  // Reset forces the IF decode so an interrupted store cannot keep its write strobe.
  assign dec_state = RST ? S_IF : state;

  always_comb begin
    IR_WR         = 1'b0;
    PC_WR         = 1'b0;
    PC_WRITE_COND = 1'b0;
    RF_WE         = 1'b0;
    ALU_WR        = 1'b0;
    MUX1          = 1'b0;
    MUX4          = 1'b0;
    REWR_MUX      = 1'b0;
    MUX2          = 2'b00;
    I_MEM_CSN     = 1'b1;
    D_MEM_CSN     = 1'b1;
    D_MEM_WEN     = 1'b1;
    D_MEM_BE      = '0;
    ERR           = 1'b0;
    case (dec_state)
      S_IF: begin
        I_MEM_CSN = RST;
        IR_WR     = I_MEM_RDY & ~RST;
        ALU_WR    = I_MEM_RDY & ~RST;
      end
      S_ID:      PC_WR = 1'b1;
      S_U_EX:    begin MUX2 = 2'b10; ALU_WR = 1'b1; PC_WR = 1'b1; end
      S_JAL_EX:  begin MUX2 = 2'b10; PC_WR = 1'b1; end
      S_BR_ID:   begin MUX2 = 2'b10; ALU_WR = 1'b1; PC_WR = 1'b1; end
      S_LI_EX,
      S_SW_EX:   begin MUX1 = 1'b1; MUX2 = 2'b10; ALU_WR = 1'b1; end
      S_R_EX:    begin MUX1 = 1'b1; MUX2 = 2'b01; ALU_WR = 1'b1; end
      S_JALR_EX: begin MUX1 = 1'b1; MUX2 = 2'b10; PC_WR = 1'b1; end
      S_BR_EX:   begin MUX1 = 1'b1; MUX2 = 2'b01; MUX4 = 1'b1; PC_WRITE_COND = 1'b1; end
      S_WB:      RF_WE = 1'b1;
      S_LW_MEM: begin
        if (!misaligned) begin
          D_MEM_CSN = 1'b0;
          D_MEM_BE  = be_calc;
        end
      end
      S_LW_WB:   begin RF_WE = 1'b1; REWR_MUX = 1'b1; end
      S_SW_MEM: begin
        if (!misaligned) begin
          D_MEM_CSN = 1'b0;
          D_MEM_WEN = 1'b0;
          D_MEM_BE  = be_calc;
        end
      end
      S_ERR:     ERR = 1'b1;
      default:   ;
    endcase
  end

  assign STATE       = state;
  assign ALU_CONTROL = {OPCODE, state};

endmodule
